// File: rtl/fx_uart_alu_core.sv
// fx_uart_alu_core: byte-serial fixed-point ALU between UART RX and TX.
// Frame in:  instruction byte, then A and B (NBYTES each, MSB first).
// Frame out: DATA_W-bit result, MSB first, one byte per Tx_Done_in handshake.
// Build option: define FX_ALU_SAT_EN to saturate ADD/SUB/MUL on overflow;
// without it those results wrap to the low DATA_W bits.
module fx_uart_alu_core #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Rx_Byte_in,
    input  logic       Rx_DV_in,
    input  logic       Tx_Done_in,
    output logic       Tx_DV_out,
    output logic [7:0] Tx_Byte_out,
    output logic       Busy_out,
    output logic       Err_out,
    output logic [7:0] c_out
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

`ifdef FX_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        RX_INS,
        RX_A,
        RX_B,
        EXE,
        SEND,
        WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [CNT_W-1:0]  idx_q,   idx_d;
    logic [7:0]        ins_q,   ins_d;
    logic [DATA_W-1:0] a_q,     a_d;
    logic [DATA_W-1:0] b_q,     b_d;
    logic [DATA_W-1:0] res_q,   res_d;
    logic              err_q,   err_d;
    logic [7:0]        c_q,     c_d;
    logic [7:0]        txb_q,   txb_d;

    logic signed [DATA_W:0]     sum_w;
    logic signed [DATA_W:0]     diff_w;
    logic signed [2*DATA_W-1:0] prod_w;
    logic signed [2*DATA_W-1:0] prod_sh;
    logic [DATA_W:0]            prod_top;
    logic                       sum_ovf, diff_ovf, prod_ovf;
    logic [DATA_W-1:0]          sum_red, diff_red, prod_red;
    logic [DATA_W-1:0]          alu_res;
    logic                       alu_err;
    logic [7:0]                 cur_byte;

    // Arithmetic datapath: widened intermediates, then wrap or clamp to DATA_W.
    always_comb begin
        sum_w    = $signed({a_q[DATA_W-1], a_q}) + $signed({b_q[DATA_W-1], b_q});
        diff_w   = $signed({a_q[DATA_W-1], a_q}) - $signed({b_q[DATA_W-1], b_q});
        prod_w   = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q})
                 * $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});
        prod_sh  = prod_w >>> FRAC_W;
        // The shifted product fits when all bits from DATA_W-1 upward agree.
        prod_top = prod_sh[2*DATA_W-1:DATA_W-1];
        sum_ovf  = sum_w[DATA_W]  != sum_w[DATA_W-1];
        diff_ovf = diff_w[DATA_W] != diff_w[DATA_W-1];
        prod_ovf = !((&prod_top) || !(|prod_top));

        sum_red  = sum_w[DATA_W-1:0];
        diff_red = diff_w[DATA_W-1:0];
        prod_red = prod_sh[DATA_W-1:0];
        if (SAT_EN && sum_ovf)  sum_red  = sum_w[DATA_W]         ? MIN_V : MAX_V;
        if (SAT_EN && diff_ovf) diff_red = diff_w[DATA_W]        ? MIN_V : MAX_V;
        if (SAT_EN && prod_ovf) prod_red = prod_sh[2*DATA_W-1]   ? MIN_V : MAX_V;
    end

    // Opcode decode: full-byte compare, anything above 0x05 is illegal.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ins_q)
            8'h00:   alu_res = sum_red;
            8'h01:   alu_res = diff_red;
            8'h02:   alu_res = prod_red;
            8'h03:   alu_res = a_q & b_q;
            8'h04:   alu_res = a_q | b_q;
            8'h05:   alu_res = a_q ^ b_q;
            default: alu_err = 1'b1;
        endcase
    end

    assign cur_byte = res_q[{idx_q, 3'b000} +: 8];

    // Next-state and register updates for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ins_d   = ins_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        c_d     = c_q;
        txb_d   = txb_q;
        case (state_q)
            RX_INS: begin
                if (Rx_DV_in) begin
                    ins_d   = Rx_Byte_in;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RX_A;
                end
            end
            RX_A: begin
                if (Rx_DV_in) begin
                    a_d = (a_q << 8) | DATA_W'(Rx_Byte_in);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = RX_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RX_B: begin
                if (Rx_DV_in) begin
                    b_d = (b_q << 8) | DATA_W'(Rx_Byte_in);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = EXE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            EXE: begin
                res_d   = alu_res;
                err_d   = alu_err;
                c_d     = alu_res[DATA_W-1 -: 8];
                idx_d   = LAST;
                state_d = SEND;
            end
            SEND: begin
                txb_d   = cur_byte;
                state_d = WAIT;
            end
            WAIT: begin
                if (Tx_Done_in) begin
                    if (idx_q == '0) begin
                        state_d = RX_INS;
                    end else begin
                        idx_d   = idx_q - CNT_W'(1);
                        state_d = SEND;
                    end
                end
            end
            default: state_d = RX_INS;
        endcase
    end

    // State and datapath registers, cleared asynchronously by RST low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RX_INS;
            cnt_q   <= '0;
            idx_q   <= '0;
            ins_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            c_q     <= '0;
            txb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ins_q   <= ins_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            c_q     <= c_d;
            txb_q   <= txb_d;
        end
    end

    // The byte is presented live in SEND and then held from txb_q.
    assign Tx_DV_out   = (state_q == SEND);
    assign Tx_Byte_out = (state_q == SEND) ? cur_byte : txb_q;
    assign Busy_out    = (state_q != RX_INS);
    assign Err_out     = err_q;
    assign c_out       = c_q;

endmodule
